// File: rtl/cpu_0_mul_seq.sv
// cpu_0_mul_seq: multi-cycle 32x32 multiply sequencer built on a single
// registered 16x16 unsigned multiplier slice.
// The sequencer issues up to four partial products into a 64-bit
// accumulator. It then applies a signed correction to the high word and
// returns either the low word (MUL) or the high word (MULXUU/MULXSU/MULXSS).
// Optional feature macro: CPU_0_MUL_SEQ_EARLY_OUT_EN. When it is defined,
// MUL/MULXUU with a zero upper half of src2 stop after two partial products.
module cpu_0_mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_fsm;
    state_t      w_next_state;

    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_last_k;
    logic [1:0]  r_k;
    logic [31:0] r_prod;
    logic [1:0]  r_prod_k;
    logic        r_prod_vld;
    logic [63:0] r_acc;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_early;
    logic [1:0]  w_last_k;
    logic [15:0] w_mul_a;
    logic [15:0] w_mul_b;
    logic [31:0] w_prod;
    logic [63:0] w_prod_shifted;
    logic [31:0] w_corr_a;
    logic [31:0] w_corr_b;
    logic [31:0] w_hi_fixed;
    logic        w_req_ready;
    logic        w_resp_valid;
    logic        w_busy;

    // State register; reset dominates, flush is folded into the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic for the issue/drain/fix/done sequence.
    always_comb begin
        w_next_fsm = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next_fsm = S_ISSUE;
                end else begin
                    w_next_fsm = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (r_k == r_last_k) begin
                    w_next_fsm = S_DRAIN;
                end else begin
                    w_next_fsm = S_ISSUE;
                end
            end
            S_DRAIN: w_next_fsm = S_FIX;
            S_FIX:   w_next_fsm = S_DONE;
            S_DONE: begin
                if (resp_ready) begin
                    w_next_fsm = S_IDLE;
                end else begin
                    w_next_fsm = S_DONE;
                end
            end
            default: w_next_fsm = S_IDLE;
        endcase
        if (flush) begin
            w_next_state = S_IDLE;
        end else begin
            w_next_state = w_next_fsm;
        end
    end

    // Moore output decode of the current state.
    always_comb begin
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                w_busy      = 1'b0;
            end
            S_DONE:  w_resp_valid = 1'b1;
            default: w_busy       = 1'b1;
        endcase
    end

    assign req_ready   = w_req_ready;
    assign resp_valid  = w_resp_valid;
    assign busy        = w_busy;
    assign resp_result = r_result;

    assign w_accept = (r_state == S_IDLE) && req_valid && !flush;

    // Decide at accept time how many partial products the request needs.
    always_comb begin
`ifdef CPU_0_MUL_SEQ_EARLY_OUT_EN
        w_early = ((req_op == 2'd0) || (req_op == 2'd1)) && (req_src2[31:16] == 16'd0);
`else
        w_early = 1'b0;
`endif
        if (w_early) begin
            w_last_k = 2'd1;
        end else if (req_op == 2'd0) begin
            w_last_k = 2'd2;
        end else begin
            w_last_k = 2'd3;
        end
    end

    // Operand halves for partial k: bit0 picks the src1 half, bit1 the src2 half.
    always_comb begin
        w_mul_a = r_k[0] ? r_a[31:16] : r_a[15:0];
        w_mul_b = r_k[1] ? r_b[31:16] : r_b[15:0];
        w_prod  = {16'd0, w_mul_a} * {16'd0, w_mul_b};
    end

    // Align the registered partial product to its weight in the 64-bit sum.
    always_comb begin
        case (r_prod_k)
            2'd0:    w_prod_shifted = {32'd0, r_prod};
            2'd1:    w_prod_shifted = {16'd0, r_prod, 16'd0};
            2'd2:    w_prod_shifted = {16'd0, r_prod, 16'd0};
            2'd3:    w_prod_shifted = {r_prod, 32'd0};
            default: w_prod_shifted = 64'd0;
        endcase
    end

    // Signed correction of the unsigned high word: subtract the other operand
    // for each operand that is treated as signed and is negative.
    always_comb begin
        if (r_op[1] && r_a[31]) begin
            w_corr_a = r_b;
        end else begin
            w_corr_a = 32'd0;
        end
        if ((r_op == 2'd3) && r_b[31]) begin
            w_corr_b = r_a;
        end else begin
            w_corr_b = 32'd0;
        end
        w_hi_fixed = r_acc[63:32] - w_corr_a - w_corr_b;
    end

    // Latch operands and op only on an accepted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= 2'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_last_k <= 2'd0;
        end else if (w_accept) begin
            r_op     <= req_op;
            r_a      <= req_src1;
            r_b      <= req_src2;
            r_last_k <= w_last_k;
        end else begin
            r_op     <= r_op;
            r_a      <= r_a;
            r_b      <= r_b;
            r_last_k <= r_last_k;
        end
    end

    // Issue counter and the one-cycle registered multiplier slice.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_k        <= 2'd0;
            r_prod     <= 32'd0;
            r_prod_k   <= 2'd0;
            r_prod_vld <= 1'b0;
        end else begin
            r_prod_vld <= (r_state == S_ISSUE);
            if (r_state == S_ISSUE) begin
                r_prod   <= w_prod;
                r_prod_k <= r_k;
                r_k      <= r_k + 2'd1;
            end else if (w_accept) begin
                r_k <= 2'd0;
            end else begin
                r_k <= r_k;
            end
        end
    end

    // Accumulate partial products mod 2^64, then fix up the high word.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_acc <= 64'd0;
        end else if (w_accept) begin
            r_acc <= 64'd0;
        end else if (r_prod_vld) begin
            r_acc <= r_acc + w_prod_shifted;
        end else if (r_state == S_FIX) begin
            r_acc <= {w_hi_fixed, r_acc[31:0]};
        end else begin
            r_acc <= r_acc;
        end
    end

    // Result word is captured in FIX and held until the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_result <= 32'd0;
        end else if (r_state == S_FIX) begin
            if (r_op == 2'd0) begin
                r_result <= r_acc[31:0];
            end else begin
                r_result <= w_hi_fixed;
            end
        end else if ((r_state == S_DONE) && resp_ready) begin
            r_result <= 32'd0;
        end else begin
            r_result <= r_result;
        end
    end

endmodule

// File: doc/cpu_0_mul_seq.md
# cpu_0_mul_seq

Multi-cycle multiply sequencer for the CPU's 16x16 unsigned hardware multiplier slice. It takes a 32x32 multiply request and issues up to four 16x16 partial products through one registered multiplier. It accumulates them into a 64-bit product, applies signed correction, and returns the low word (MUL) or the high word (MULXUU/MULXSU/MULXSS). It sits between the execute stage and the multiplier DSP block, and replaces the two-multiplier low-word-only cell when full-product instructions are enabled.

## Interface
- No parameters; all widths fixed: operands 32, multiplier slice 16x16→32, accumulator 64.
- One clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous abort of any in-flight operation.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  0=MUL (low word), 1=MULXUU, 2=MULXSU (src1 signed, src2 unsigned), 3=MULXSS.
- req_src1  in  32  operand A.
- req_src2  in  32  operand B.
- resp_valid  out  1  result valid; held until accepted.
- resp_ready  in  1  consumer accepts.
- resp_result  out  32  selected result word.
- busy  out  1  high in any state other than IDLE.

## Operation
- Operands and op are latched on the accept cycle: req_valid && req_ready.
- Partial product k, fixed issue order, one per cycle; a0/a1 = src1 low/high half, b0/b1 = src2 low/high half.
  - k0: a0*b0, shifted 0.
  - k1: a1*b0, shifted 16.
  - k2: a0*b1, shifted 16.
  - k3: a1*b1, shifted 32.
  - MUL issues k0..k2 only.
- Internal multiplier stage is registered, 1 cycle. The product of the issue at cycle t is added into the 64-bit unsigned accumulator at t+1. Accumulation is modulo 2^64.
- States and transitions:
  - IDLE: accept → ISSUE.
  - ISSUE: one partial per cycle; after the last issue → DRAIN.
  - DRAIN: add the last product → FIX.
  - FIX: apply signed correction to acc[63:32], mod 2^32 → DONE.
    - MULXSU: hi -= (A[31] ? B : 0).
    - MULXSS: hi -= (A[31] ? B : 0) + (B[31] ? A : 0).
    - MUL and MULXUU: no change.
  - DONE: resp_valid=1; resp_ready → IDLE.
- resp_result is acc[31:0] for MUL and acc[63:32] otherwise. It is stable while resp_valid is high.
- A new request is never accepted in the same cycle a response is consumed. The first accept opportunity is the cycle after the DONE→IDLE transition.
- flush or reset in any state → IDLE next cycle. Accumulator is cleared, resp_valid=0, and the result is discarded.
  - flush while in DONE discards an unaccepted result.
  - reset has priority over flush; both give the same outcome.
- req_valid asserted outside IDLE is ignored, and no state is latched.

## Timing
- Reset values: req_ready=1, resp_valid=0, busy=0, resp_result=0, state=IDLE.
- Accept at cycle T:
  - MULX*: issues T+1..T+4, DRAIN T+5, FIX T+6, resp_valid from T+7.
  - MUL: issues T+1..T+3, DRAIN T+4, FIX T+5, resp_valid from T+6.
- req_ready falls at T+1 and rises the cycle after resp_valid && resp_ready.
- Throughput with resp_ready tied high: one MULX* per 8 cycles, one MUL per 7 cycles.

## Configuration
- Macro: CPU_0_MUL_SEQ_EARLY_OUT_EN.
- Defined: for op MUL or MULXUU with req_src2[31:16]==0, only k0 and k1 are issued (T+1..T+2), DRAIN at T+3, FIX at T+4, resp_valid from T+5. Signed ops never take the early-out.
- Undefined: fixed latency as listed under Timing. Results are identical in both builds.

## Test plan
- MUL 0x0001_0003 * 0x0002_0005, resp_ready=1 → resp_result 0x000B_000F, resp_valid exactly at T+6, req_ready high at T+7.
- MULXUU 0xFFFF_FFFF * 0xFFFF_FFFF → 0xFFFF_FFFE at T+7.
- Signed high word:
  - MULXSS 0xFFFF_FFFF * 0x0000_0002 → 0xFFFF_FFFF.
  - MULXSU 0xFFFF_FFFF * 0xFFFF_FFFF → 0xFFFF_FFFF.
  - MULXSS 0x8000_0000 * 0x8000_0000 → 0x4000_0000.
- Backpressure: MUL 0x0000_0007 * 0x0000_0006 with resp_ready low 5 cycles.
  - resp_valid stays 1 and resp_result stays 0x0000_002A.
  - req_ready stays 0, and a req_valid pulse during the wait is ignored.
- Reset asserted at T+3 of a MULXSS → next cycle req_ready=1, resp_valid=0, busy=0. Flush at T+3 gives the same result.
- MUL 0x1234_5678 * 0x0000_0010 → 0x2345_6780.
  - resp_valid at T+5 with CPU_0_MUL_SEQ_EARLY_OUT_EN defined, T+6 without.
  - MULXSS with the same operands → 0x0000_0001 at T+7 in both builds.
